// File: rtl/izh_pkg.sv
// ---------------------------------------------------------------------------
// izh_pkg
// Shared definitions for the Izhikevich spike monitor slice: default field
// widths, the "no ISI measured" marker and the monitor state encoding.
// ---------------------------------------------------------------------------
package izh_pkg;

  localparam int DEF_WIN_W = 16;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_ISI_W = 12;

  // All-ones min-ISI means fewer than two events were seen to measure between
  localparam logic [DEF_ISI_W-1:0] ISI_NONE = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/izh_spike_monitor_if.sv
// ---------------------------------------------------------------------------
// izh_spike_monitor_if
// Valid/ready summary-record channel from the spike monitor to the readout.
//   out_valid   : record available (producer)
//   out_ready   : consumer accepts record (consumer)
//   out_count   : spikes in the completed window
//   out_isi_min : minimum inter-spike interval, all-ones = none measured
//   out_vpeak   : maximum membrane value seen in the window
// ---------------------------------------------------------------------------
interface izh_spike_monitor_if #(
  parameter int CNT_W = izh_pkg::DEF_CNT_W,
  parameter int ISI_W = izh_pkg::DEF_ISI_W
);

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [ISI_W-1:0] out_isi_min;
  logic [7:0]       out_vpeak;

  modport master (
    output out_valid,
    output out_count,
    output out_isi_min,
    output out_vpeak,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_isi_min,
    input  out_vpeak,
    output out_ready
  );

endinterface

// File: rtl/izh_edge_counter.sv
// ---------------------------------------------------------------------------
// izh_edge_counter
// Rising-edge spike detection plus the per-window spike count and the
// running inter-spike-interval measurement.
//   clk, reset_n : clock, asynchronous active-low reset
//   spike        : neuron spike level
//   start        : window sequence is starting from idle (clear accumulators)
//   run          : a monitored cycle is in progress
//   abort        : monitoring stopped mid-window (drop ISI history)
//   win_end      : current run cycle is the last of the window
//   count_fin    : spike count including this cycle's event
//   isi_min_fin  : minimum ISI including this cycle's event
// ---------------------------------------------------------------------------
module izh_edge_counter import izh_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike,
  input  logic             start,
  input  logic             run,
  input  logic             abort,
  input  logic             win_end,
  output logic [CNT_W-1:0] count_fin,
  output logic [ISI_W-1:0] isi_min_fin
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic             spike_d;
  logic             evt;
  logic             have_prev;
  logic [CNT_W-1:0] acc_count;
  logic [ISI_W-1:0] acc_isi_min;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_next;

  // A spike held high for several cycles is a single event
  assign evt = spike & ~spike_d;

  // Window totals as they stand after this cycle, so the last cycle's event
  // is included in the record committed at window end
  always_comb begin
    count_fin   = acc_count;
    isi_min_fin = acc_isi_min;
    isi_next    = isi_cnt;
    if (evt && (acc_count != CNT_MAX)) begin
      count_fin = acc_count + CNT_W'(1);
    end
    if (evt && have_prev && (isi_cnt < acc_isi_min)) begin
      isi_min_fin = isi_cnt;
    end
    if (evt) begin
      isi_next = ISI_W'(1);
    end else if (isi_cnt != ISI_MAX) begin
      isi_next = isi_cnt + ISI_W'(1);
    end
  end

  // ISI history survives window boundaries; only an abort or reset drops it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_d     <= 1'b0;
      have_prev   <= 1'b0;
      acc_count   <= '0;
      acc_isi_min <= '0;
      isi_cnt     <= '0;
    end else begin
      spike_d <= spike;
      if (start) begin
        acc_count   <= '0;
        acc_isi_min <= ISI_MAX;
      end else if (run) begin
        isi_cnt   <= isi_next;
        have_prev <= have_prev | evt;
        if (win_end) begin
          acc_count   <= '0;
          acc_isi_min <= ISI_MAX;
        end else begin
          acc_count   <= count_fin;
          acc_isi_min <= isi_min_fin;
        end
      end else if (abort) begin
        isi_cnt   <= '0;
        have_prev <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/izh_spike_monitor.sv
// ---------------------------------------------------------------------------
// izh_spike_monitor
// Watches the neuron spike flag and membrane value over fixed-length windows
// and emits one {count, min ISI, peak v} record per window over valid/ready.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : monitoring enable
//   window_len   : window length in cycles (0 behaves as 1), sampled per window
//   spike, v     : neuron spike level and unsigned membrane value
//   out_bus      : summary record channel (master side)
//   out_overrun  : sticky, a completed window's record was dropped
//   busy         : monitor is in the RUN state
// ---------------------------------------------------------------------------
module izh_spike_monitor import izh_pkg::*; #(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [WIN_W-1:0]  window_len,
  input  logic              spike,
  input  logic [7:0]        v,
  izh_spike_monitor_if.master out_bus,
  output logic              out_overrun,
  output logic              busy
);

  state_t           state;
  state_t           state_next;
  logic             start;
  logic             run;
  logic             abort;
  logic             win_end;
  logic             commit_load;
  logic             commit_drop;
  logic             accept;
  logic [WIN_W-1:0] cyc;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_len_sel;
  logic [7:0]       acc_vpeak;
  logic [7:0]       vpeak_fin;
  logic [CNT_W-1:0] count_fin;
  logic [ISI_W-1:0] isi_min_fin;

  izh_edge_counter #(
    .CNT_W (CNT_W),
    .ISI_W (ISI_W)
  ) u_edge (
    .clk         (clk),
    .reset_n     (reset_n),
    .spike       (spike),
    .start       (start),
    .run         (run),
    .abort       (abort),
    .win_end     (win_end),
    .count_fin   (count_fin),
    .isi_min_fin (isi_min_fin)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    run        = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (en) begin
          run = 1'b1;
        end else begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero length would never reach its last cycle, so it is run as 1
  assign win_len_sel = (window_len == '0) ? WIN_W'(1) : window_len;
  assign win_end     = run && (cyc == (win_len_q - WIN_W'(1)));
  assign vpeak_fin   = (v > acc_vpeak) ? v : acc_vpeak;
  assign busy        = (state == RUN);

  // A held record can be replaced in the same edge it is consumed
  assign accept      = out_bus.out_valid & out_bus.out_ready;
  assign commit_load = win_end & (~out_bus.out_valid | out_bus.out_ready);
  assign commit_drop = win_end & out_bus.out_valid & ~out_bus.out_ready;

  // Window accumulators restart in the window-end edge itself, so windows
  // follow back to back with no gap cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cyc       <= '0;
      win_len_q <= '0;
      acc_vpeak <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        win_len_q <= win_len_sel;
        cyc       <= '0;
        acc_vpeak <= '0;
      end else if (run) begin
        if (win_end) begin
          win_len_q <= win_len_sel;
          cyc       <= '0;
          acc_vpeak <= '0;
        end else begin
          cyc       <= cyc + WIN_W'(1);
          acc_vpeak <= vpeak_fin;
        end
      end
    end
  end

  // Fields hold their last record after consumption and while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_bus.out_valid   <= 1'b0;
      out_bus.out_count   <= '0;
      out_bus.out_isi_min <= '0;
      out_bus.out_vpeak   <= '0;
      out_overrun         <= 1'b0;
    end else if (commit_load) begin
      out_bus.out_valid   <= 1'b1;
      out_bus.out_count   <= count_fin;
      out_bus.out_isi_min <= isi_min_fin;
      out_bus.out_vpeak   <= vpeak_fin;
    end else begin
      if (commit_drop) begin
        out_overrun <= 1'b1;
      end
      if (accept) begin
        out_bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_izh_spike_monitor.sv
// ---------------------------------------------------------------------------
// tb_izh_spike_monitor
// Self-checking bench for izh_spike_monitor: table of single-window vectors
// plus hand-written multi-cycle sequences; records are checked against a
// queue of expected results as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_izh_spike_monitor;
  import izh_pkg::*;

  typedef struct {
    logic [7:0]  count;
    logic [11:0] isi;
    logic [7:0]  vpeak;
  } rec_t;

  typedef struct {
    int          winLen;
    logic [31:0] mask;
    int          pkCyc;
    logic [7:0]  pkVal;
    logic [7:0]  expCount;
    logic [11:0] expIsi;
    logic [7:0]  expVpeak;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [15:0] window_len;
  logic        spike;
  logic [7:0]  v;
  logic        out_overrun;
  logic        busy;

  rec_t expq[$];
  rec_t monExp;
  vec_t vecs[5];
  vec_t vec;
  int   checks   = 0;
  int   failures = 0;

  izh_spike_monitor_if #(.CNT_W(DEF_CNT_W), .ISI_W(DEF_ISI_W)) bus ();

  izh_spike_monitor #(
    .WIN_W (DEF_WIN_W),
    .CNT_W (DEF_CNT_W),
    .ISI_W (DEF_ISI_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .window_len  (window_len),
    .spike       (spike),
    .v           (v),
    .out_bus     (bus.master),
    .out_overrun (out_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Each handshake consumes the oldest expected record
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_record: got count=%0d isi=0x%0h vpeak=%0d expected no record",
                 bus.out_count, bus.out_isi_min, bus.out_vpeak);
      end else begin
        monExp = expq.pop_front();
        checkOutput("rec_count", 32'(bus.out_count), 32'(monExp.count));
        checkOutput("rec_isi_min", 32'(bus.out_isi_min), 32'(monExp.isi));
        checkOutput("rec_vpeak", 32'(bus.out_vpeak), 32'(monExp.vpeak));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n       = 1'b0;
    en            = 1'b0;
    spike         = 1'b0;
    v             = 8'd0;
    window_len    = 16'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input int idx);
    vec = vecs[idx];
    doReset();
    expq.push_back('{vec.expCount, vec.expIsi, vec.expVpeak});
    window_len = 16'(vec.winLen);
    en         = 1'b1;
    step();
    for (int k = 0; k < vec.winLen; k++) begin
      spike = vec.mask[k];
      v     = (k == vec.pkCyc) ? vec.pkVal : 8'(k);
      if (k == 1) checkOutput($sformatf("busy_run_%0d", idx), 32'(busy), 32'd1);
      step();
    end
    checkOutput($sformatf("valid_after_window_%0d", idx), 32'(bus.out_valid), 32'd1);
    en    = 1'b0;
    spike = 1'b0;
    v     = 8'd0;
    step();
    step();
    checkOutput($sformatf("queue_drained_%0d", idx), 32'(expq.size()), 32'd0);
  endtask

  initial begin
    // winLen, spike mask (bit k = window cycle k), peak cycle, peak v, expected record
    vecs[0] = '{10, 32'h0000_0084, 5,  8'd45,  8'd2, 12'd5,   8'd45};
    vecs[1] = '{8,  32'h0000_001E, 7,  8'd200, 8'd1, 12'hFFF, 8'd200};
    vecs[2] = '{6,  32'h0000_0025, 0,  8'd100, 8'd3, 12'd2,   8'd100};
    vecs[3] = '{12, 32'h0000_0555, 11, 8'd255, 8'd6, 12'd2,   8'd255};
    vecs[4] = '{20, 32'h0000_0000, 0,  8'd3,   8'd0, 12'hFFF, 8'd19};

    doReset();
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_count", 32'(bus.out_count), 32'd0);
    checkOutput("reset_isi", 32'(bus.out_isi_min), 32'd0);
    checkOutput("reset_vpeak", 32'(bus.out_vpeak), 32'd0);
    checkOutput("reset_overrun", 32'(out_overrun), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(i);

    // window_len=0 acts as 1: a record every cycle
    doReset();
    window_len = 16'd0;
    en         = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      spike = (k % 2 == 0);
      v     = 8'(k * 3 + 1);
      expq.push_back('{(k % 2 == 0) ? 8'd1 : 8'd0,
                       (k >= 2 && k % 2 == 0) ? 12'd2 : ISI_NONE,
                       8'(k * 3 + 1)});
      step();
      checkOutput($sformatf("len0_valid_%0d", k), 32'(bus.out_valid), 32'd1);
    end
    en    = 1'b0;
    spike = 1'b0;
    step();
    step();
    checkOutput("len0_overrun", 32'(out_overrun), 32'd0);
    checkOutput("len0_drained", 32'(expq.size()), 32'd0);

    // Stalled consumer: first record held, later windows dropped
    doReset();
    window_len    = 16'd4;
    bus.out_ready = 1'b0;
    en            = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      if (k == 4) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_count", 32'(bus.out_count), 32'd1);
        checkOutput("stall_isi", 32'(bus.out_isi_min), 32'hFFF);
        checkOutput("stall_vpeak", 32'(bus.out_vpeak), 32'd50);
        checkOutput("stall_overrun_early", 32'(out_overrun), 32'd0);
      end
      spike = (k == 1 || k == 5);
      v     = (k == 2) ? 8'd50 : 8'(k % 4);
      step();
    end
    spike = 1'b0;
    checkOutput("overrun_set", 32'(out_overrun), 32'd1);
    checkOutput("held_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("held_isi", 32'(bus.out_isi_min), 32'hFFF);
    checkOutput("held_vpeak", 32'(bus.out_vpeak), 32'd50);
    expq.push_back('{8'd1, 12'hFFF, 8'd50});
    bus.out_ready = 1'b1;
    en            = 1'b0;
    step();
    checkOutput("stall_valid_fall", 32'(bus.out_valid), 32'd0);
    checkOutput("overrun_sticky", 32'(out_overrun), 32'd1);
    checkOutput("stall_drained", 32'(expq.size()), 32'd0);

    // Asynchronous reset in the middle of a window
    window_len = 16'd10;
    en         = 1'b1;
    step();
    step();
    step();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_count", 32'(bus.out_count), 32'd0);
    checkOutput("async_isi", 32'(bus.out_isi_min), 32'd0);
    checkOutput("async_vpeak", 32'(bus.out_vpeak), 32'd0);
    checkOutput("async_overrun", 32'(out_overrun), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);

    // ISI measured across a window boundary
    doReset();
    window_len = 16'd5;
    expq.push_back('{8'd1, 12'hFFF, 8'd8});
    expq.push_back('{8'd1, 12'd3, 8'd18});
    en = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      spike = (k == 3 || k == 6);
      v     = 8'(k * 2);
      step();
    end
    en    = 1'b0;
    spike = 1'b0;
    step();
    step();
    checkOutput("xwin_drained", 32'(expq.size()), 32'd0);

    // Disable mid-window: no record, no ISI carried into the next run
    doReset();
    window_len = 16'd10;
    en         = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      spike = (k == 1);
      v     = 8'd90;
      step();
    end
    en    = 1'b0;
    spike = 1'b0;
    step();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    step();
    step();
    expq.push_back('{8'd1, 12'hFFF, 8'd7});
    window_len = 16'd6;
    en         = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      spike = (k == 2);
      v     = 8'(k + 2);
      step();
    end
    en    = 1'b0;
    spike = 1'b0;
    step();
    step();
    checkOutput("abort_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/izh_spike_monitor.md
Name: izh_spike_monitor

Overview:
- Downstream consumer of the Izhikevich neuron stage. Watches the neuron's spike flag and 8-bit membrane value v over fixed-length windows of clock cycles.
- At the end of each window it emits one summary record over a valid/ready handshake:
  - spike count
  - minimum inter-spike interval (ISI)
  - peak v
- Feeds the output mux / readout logic. The neuron can be characterised (firing rate, burst timing) without raw per-cycle observation.

Parameters:
- WIN_W, 16, width of window length and window cycle counter
- CNT_W, 8, width of per-window spike count (saturating)
- ISI_W, 12, width of ISI counter and min-ISI result (saturating)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- en  input  1  monitoring enable
- window_len  input  WIN_W  window length in cycles, sampled at window start
- spike  input  1  neuron spike flag (level)
- v  input  8  neuron membrane value (unsigned)
- out_valid  output  1  summary record available
- out_ready  input  1  consumer accepts record
- out_count  output  CNT_W  spikes in completed window
- out_isi_min  output  ISI_W  minimum ISI in window; all-ones = none measured
- out_vpeak  output  8  maximum v sampled in window
- out_overrun  output  1  sticky: a window result was dropped
- busy  output  1  high in RUN state

Behaviour:
- Reset (async assert, sync-released use on next clk edge):
  - out_valid=0, out_count=0, out_isi_min=0, out_vpeak=0, out_overrun=0, busy=0.
  - All internal counters =0; spike_d=0; have_prev=0; state=IDLE.
- Spike event:
  - event = spike & ~spike_d, where spike_d is spike registered each cycle.
  - A spike held high across N cycles counts once.
- State machine:
  - IDLE: when en=1, latch win_len_q = (window_len==0 ? 1 : window_len). Clear cyc, acc_count, acc_vpeak, and set acc_isi_min to all-ones. Go to RUN on the next cycle.
  - RUN: each cycle, cyc += 1; acc_vpeak = max(acc_vpeak, v).
    - On event: acc_count += 1, saturating at 2^CNT_W-1.
    - If have_prev=1 on an event: acc_isi_min = min(acc_isi_min, isi_cnt).
    - On every event: isi_cnt <- 1; have_prev <- 1.
    - On non-event cycles: isi_cnt += 1, saturating at 2^ISI_W-1.
  - Window end: the cycle where cyc == win_len_q-1. The event and v sample on that cycle belong to the ending window.
    - The final values are committed to the output register at that edge.
    - The accumulators restart for the next window in the same edge, so there are no gap cycles.
    - win_len_q is re-sampled from window_len (0 treated as 1).
  - en=0 in RUN: return to IDLE next cycle. Partial window discarded; no record emitted. have_prev and isi_cnt cleared. The output register is untouched.
- ISI across windows: isi_cnt and have_prev persist across window boundaries while en=1. The first event of a window measures from the last event of the previous window.
- Output handshake:
  - Commit at window end when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle: load fields, out_valid=1.
  - Commit at window end when out_valid=1 and out_ready=0: new record dropped, out_overrun<=1. The held record is unchanged.
  - out_valid & out_ready with no commit: out_valid<=0.
  - Fields are stable while out_valid=1 and out_ready=0.
  - out_overrun clears only on reset.
- Latency: out_valid rises on the clock edge that ends the window's last cycle. It is visible the first cycle after the window.
- Arithmetic: all unsigned; saturating increments; no wrap of count or ISI.

Decomposition:
- Shared package izh_pkg:
  - default widths: WIN_W, CNT_W, ISI_W
  - ISI_NONE constant (all-ones)
  - state enum: IDLE, RUN
- One natural sub-module: izh_edge_counter. It holds the spike_d register, event detect, and saturating count/ISI logic. The parent holds the FSM, window counter, vpeak and output register.

Test Plan:
- Window behaviour:
  - reset, en=1, window_len=10, spike pulses (1 cycle) at window cycles 2 and 7, v peak 45 -> out_valid after 10th cycle; count=2, isi_min=5, vpeak=45.
  - window_len=8, spike held high cycles 1–4, no other spikes -> count=1, isi_min=all-ones (0xFFF), vpeak as driven.
  - window_len=0 -> treated as 1; each cycle produces a record. Keep out_ready=1 -> one record per cycle, no overrun.
- Handshake and overrun: window_len=4, out_ready=0 for 12 cycles -> first record held stable; out_overrun=1 after the second window end. Then out_ready=1 for one cycle -> out_valid falls, first record's values observed.
- Cross-window ISI: window_len=5, spikes at absolute cycles 3 and 6 (different windows) -> window 2 reports count=1, isi_min=3.
- Mid-operation events:
  - en=0 at window cycle 3 of 10 -> no record; busy falls; later en=1 starts a fresh window with no ISI carry.
  - reset_n asserted mid-window -> all outputs 0 immediately (asynchronous), out_overrun cleared.
